// File: rtl/contador_asc_desc_if.sv
// ============================================================================
//  contador_asc_desc_if : button inputs and display/status outputs of the
//  up/down counter stage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface contador_asc_desc_if;
  logic       step_in;
  logic       dir_in;
  logic [6:0] count;
  logic [6:0] seg_tens;
  logic [6:0] seg_units;
  logic       dir_down;
  logic       wrap_pulse;

  modport master (
    output step_in,
    output dir_in,
    input  count,
    input  seg_tens,
    input  seg_units,
    input  dir_down,
    input  wrap_pulse
  );

  modport slave (
    input  step_in,
    input  dir_in,
    output count,
    output seg_tens,
    output seg_units,
    output dir_down,
    output wrap_pulse
  );
endinterface

`default_nettype wire

// File: rtl/contador_asc_desc.sv
// ============================================================================
//  contador_asc_desc : modulo up/down counter with auto-repeat step button,
//  direction toggle and two-digit active-low 7-segment display.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module contador_asc_desc #(
  parameter int MODULO        = 60,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic                clock_fpga,
  input  logic                reset_n,
  contador_asc_desc_if.slave  bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
  localparam logic [6:0]         COUNT_MAX   = 7'(MODULO - 1);
  localparam logic [6:0]         SEG_ZERO    = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  step_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               step_prev_q;
  logic               dir_prev_q;
  logic [6:0]         count_q, count_d;
  logic               dir_down_q, dir_down_d;
  logic               wrap_q, wrap_d;
  logic [6:0]         seg_tens_q;
  logic [6:0]         seg_units_q;

  logic step_rise;
  logic dir_rise;
  logic step_fire;

  // Active-low {g,f,e,d,c,b,a}; anything out of range shows blank.
  function automatic logic [6:0] seg7(input logic [6:0] digit);
    logic [6:0] seg;
    case (digit)
      7'd0:    seg = 7'b1000000;
      7'd1:    seg = 7'b1111001;
      7'd2:    seg = 7'b0100100;
      7'd3:    seg = 7'b0110000;
      7'd4:    seg = 7'b0011001;
      7'd5:    seg = 7'b0010010;
      7'd6:    seg = 7'b0000010;
      7'd7:    seg = 7'b1111000;
      7'd8:    seg = 7'b0000000;
      7'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  assign step_rise = bus.step_in & ~step_prev_q;
  assign dir_rise  = bus.dir_in  & ~dir_prev_q;

  // Edge-detect history resets high so a button held through reset is ignored
  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      step_prev_q <= 1'b1;
      dir_prev_q  <= 1'b1;
    end else begin
      step_prev_q <= bus.step_in;
      dir_prev_q  <= bus.dir_in;
    end
  end

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    step_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (step_rise) begin
          step_fire = 1'b1;
          timer_d   = '0;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!bus.step_in) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (timer_q == HOLD_LAST) begin
          step_fire = 1'b1;
          timer_d   = '0;
          state_d   = ST_REPEAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!bus.step_in) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (timer_q == REPEAT_LAST) begin
          step_fire = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // A step uses the direction held before this edge; a same-edge toggle only
  // affects later steps.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    dir_down_d = dir_down_q ^ dir_rise;
    if (step_fire) begin
      if (!dir_down_q) begin
        if (count_q == COUNT_MAX) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 7'd1;
        end
      end else begin
        if (count_q == 7'd0) begin
          count_d = COUNT_MAX;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      dir_down_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      dir_down_q <= dir_down_d;
      wrap_q     <= wrap_d;
    end
  end

  always_ff @(posedge clock_fpga or negedge reset_n) begin
    if (!reset_n) begin
      seg_tens_q  <= SEG_ZERO;
      seg_units_q <= SEG_ZERO;
    end else begin
      seg_tens_q  <= seg7(count_q / 7'd10);
      seg_units_q <= seg7(count_q % 7'd10);
    end
  end

  assign bus.count      = count_q;
  assign bus.seg_tens   = seg_tens_q;
  assign bus.seg_units  = seg_units_q;
  assign bus.dir_down   = dir_down_q;
  assign bus.wrap_pulse = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_asc_desc.sv
// ============================================================================
//  tb_contador_asc_desc : directed-vector bench for contador_asc_desc with
//  MODULO=60, HOLD_CYCLES=8, REPEAT_CYCLES=4.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_contador_asc_desc;

  logic clock_fpga = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  contador_asc_desc_if bus ();

  contador_asc_desc #(
    .MODULO        (60),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .clock_fpga (clock_fpga),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  always #5 clock_fpga = ~clock_fpga;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  task automatic tick();
    @(posedge clock_fpga);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One-cycle press then release; seg digits are checked only where known.
  task automatic press(input string tag, input int exp_count, input logic exp_wrap);
    bus.step_in = 1'b1;
    tick();
    check_val({tag, "_count"}, 32'(bus.count), 32'(exp_count));
    check_val({tag, "_wrap"},  32'(bus.wrap_pulse), 32'(exp_wrap));
    bus.step_in = 1'b0;
    tick();
    check_val({tag, "_wrapclr"}, 32'(bus.wrap_pulse), 32'd0);
  endtask

  task automatic toggle_dir(input string tag, input logic exp_dir);
    bus.dir_in = 1'b1;
    tick();
    check_val(tag, 32'(bus.dir_down), 32'(exp_dir));
    bus.dir_in = 1'b0;
    tick();
  endtask

  initial begin
    int exp_steps;

    bus.step_in = 1'b1;
    bus.dir_in  = 1'b0;
    reset_n     = 1'b0;
    repeat (3) @(posedge clock_fpga);
    #1;
    check_val("rst_count", 32'(bus.count), 32'd0);
    check_val("rst_tens",  32'(bus.seg_tens), 32'(SEG_0));
    check_val("rst_units", 32'(bus.seg_units), 32'(SEG_0));
    check_val("rst_dir",   32'(bus.dir_down), 32'd0);
    check_val("rst_wrap",  32'(bus.wrap_pulse), 32'd0);

    // Button held through reset release must not step.
    reset_n = 1'b1;
    repeat (100) tick();
    check_val("held_count", 32'(bus.count), 32'd0);
    check_val("held_tens",  32'(bus.seg_tens), 32'(SEG_0));
    check_val("held_units", 32'(bus.seg_units), 32'(SEG_0));
    bus.step_in = 1'b0;
    tick();

    press("up1", 1, 1'b0);
    press("up2", 2, 1'b0);
    press("up3", 3, 1'b0);
    check_val("seg3_units", 32'(bus.seg_units), 32'(SEG_3));
    check_val("seg3_tens",  32'(bus.seg_tens), 32'(SEG_0));

    toggle_dir("dir_down1", 1'b1);
    press("dn2", 2, 1'b0);
    press("dn1", 1, 1'b0);
    press("dn0", 0, 1'b0);
    press("dn_wrap", 59, 1'b1);
    check_val("seg59_tens",  32'(bus.seg_tens), 32'(SEG_5));
    check_val("seg59_units", 32'(bus.seg_units), 32'(SEG_9));

    toggle_dir("dir_up1", 1'b0);
    press("up_wrap", 0, 1'b1);
    check_val("seg0_units", 32'(bus.seg_units), 32'(SEG_0));

    // Hold 20 cycles: steps at edges 0, 8, 12, 16.
    bus.step_in = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      exp_steps = 1 + ((e >= 8) ? 1 : 0) + ((e >= 12) ? 1 : 0) + ((e >= 16) ? 1 : 0);
      check_val($sformatf("hold_e%0d", e), 32'(bus.count), 32'(exp_steps));
    end
    bus.step_in = 1'b0;
    repeat (10) tick();
    check_val("hold_release", 32'(bus.count), 32'd4);

    press("up5", 5, 1'b0);
    bus.step_in = 1'b1;
    bus.dir_in  = 1'b1;
    tick();
    check_val("same_count", 32'(bus.count), 32'd6);
    check_val("same_dir",   32'(bus.dir_down), 32'd1);
    bus.step_in = 1'b0;
    bus.dir_in  = 1'b0;
    tick();
    press("after_same", 5, 1'b0);
    toggle_dir("dir_up2", 1'b0);

    // Hold from 5 up: 37 reached at edge 128, inside REPEAT.
    bus.step_in = 1'b1;
    for (int e = 0; e < 130; e++) begin
      tick();
      if (e == 128) check_val("rep_37", 32'(bus.count), 32'd37);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_count", 32'(bus.count), 32'd0);
    check_val("async_tens",  32'(bus.seg_tens), 32'(SEG_0));
    check_val("async_units", 32'(bus.seg_units), 32'(SEG_0));
    check_val("async_dir",   32'(bus.dir_down), 32'd0);
    check_val("async_wrap",  32'(bus.wrap_pulse), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check_val("post_rst_count", 32'(bus.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/contador_asc_desc.md
# contador_asc_desc

Up/down counter stage fed by the button debounce filters on the 50 MHz board clock. Consumes two filtered, level-type button signals: one steps the count, one toggles direction. Holding the step button auto-repeats. Drives a two-digit active-low 7-segment display plus status outputs.

## Interface
- MODULO, 60, count range 0..MODULO-1; legal 2..100
- HOLD_CYCLES, 25_000_000, cycles step button must stay high after the first step before auto-repeat starts (0.5 s)
- REPEAT_CYCLES, 5_000_000, cycles between auto-repeat steps (0.1 s)

Ports (one clock; reset is asynchronous and active-low):
- clock_fpga  in  1  board clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- step_in  in  1  filtered step button, level, synchronous to clock_fpga
- dir_in  in  1  filtered direction button, level, synchronous to clock_fpga
- count  out  7  current count, binary
- seg_tens  out  7  tens digit, active-low segments {g,f,e,d,c,b,a}
- seg_units  out  7  units digit, same encoding
- dir_down  out  1  0 = counting up, 1 = counting down
- wrap_pulse  out  1  one-cycle pulse when a step wraps

## Operation
- Edge detect: step_prev, dir_prev register inputs each cycle; rising edge = in & ~prev.
- Direction: rising edge of dir_in toggles dir_down.
- Step FSM, states IDLE, HOLD, REPEAT, timer sized for max(HOLD_CYCLES, REPEAT_CYCLES):
  - IDLE: step_in rising edge -> one step, timer=0, go HOLD.
  - HOLD: step_in low -> IDLE. timer==HOLD_CYCLES-1 -> one step, timer=0, go REPEAT. Else timer+1.
  - REPEAT: step_in low -> IDLE. timer==REPEAT_CYCLES-1 -> one step, timer=0. Else timer+1.
- Step, up: count==MODULO-1 -> 0 with wrap_pulse; else count+1.
- Step, down: count==0 -> MODULO-1 with wrap_pulse; else count-1.
- Step and direction toggle on same edge: step uses direction held before that edge; toggle takes effect for later steps.
- Display: tens = count/10, units = count%10, each decoded to active-low 7-seg (0 -> 1000000, 1 -> 1111001, ..., 9 -> 0010000). Tens digit shown even when 0.

## Timing
- Reset (async assert, any time): count=0, dir_down=0, wrap_pulse=0, FSM=IDLE, timer=0, seg_tens=seg_units=1000000. step_prev and dir_prev reset to 1, so a button already high at reset release produces no step/toggle; it must be released and pressed again.
- Reset mid-hold/repeat: FSM to IDLE immediately, no step pending after release.
- Step latency: step_in first sampled 1 at edge N (sampled 0 at N-1) -> count updated at edge N; seg_* updated at edge N+1 (registered decode).
- wrap_pulse high for exactly the cycle after the wrapping edge (asserted at edge N, cleared at N+1 unless another wrap).
- dir_in toggle: dir_down changes at edge where rising edge is sampled.
- Held button: steps at edge N, N+HOLD_CYCLES, then every REPEAT_CYCLES. Release (sampled 0) at any point returns to IDLE on that edge, no step on that edge.
- Max one step per cycle; no state besides count/dir changes count.

## Test plan
- Reset with step_in=1 held, release reset_n, keep step_in=1 for 100 cycles -> count stays 0, seg_units=seg_tens=1000000.
- MODULO=60: 3 single press/release pulses up -> count=3 one edge after each sampled rise, seg_units=0110000 one cycle after count=3.
- MODULO=60, count=59, press -> count=0, wrap_pulse high one cycle; toggle dir, press at 0 -> count=59, wrap_pulse one cycle.
- HOLD_CYCLES=8, REPEAT_CYCLES=4: hold step_in 20 cycles from 0 up -> steps at cycles 0, 8, 12, 16; count=4; release -> no further steps.
- Step and dir rising edges same cycle at count=5 up -> count=6, dir_down=1; next press -> count=5.
- Assert reset_n low mid-REPEAT at count=37 -> outputs return to reset values asynchronously, before next clock edge.
